// File: rtl/l1_line_fill_unit.sv
// l1_line_fill_unit: L1 miss refill engine issuing sequential beat reads and assembling the line
// Optional critical-word-first ordering under L1_FILL_CRITICAL_WORD_FIRST_EN.
module l1_line_fill_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_SIZE  = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            fill_req,
  input  logic [ADDR_WIDTH-1:0]                           fill_addr,
  input  logic [ID_WIDTH-1:0]                             fill_id,
  output logic                                            fill_ack,
  output logic                                            fill_beat_valid,
  output logic [DATA_WIDTH-1:0]                           fill_beat_data,
  output logic [$clog2(LINE_SIZE/(DATA_WIDTH/8))-1:0]     fill_beat_idx,
  output logic                                            fill_done,
  output logic                                            fill_error,
  output logic [LINE_SIZE*8-1:0]                          line_data,
  output logic [ADDR_WIDTH-1:0]                           mem_addr,
  output logic                                            mem_read,
  output logic                                            mem_write,
  output logic [DATA_WIDTH-1:0]                           mem_write_data,
  output logic [ID_WIDTH-1:0]                             mem_id,
  output logic                                            mem_request,
  input  logic [DATA_WIDTH-1:0]                           mem_read_data,
  input  logic                                            mem_ready,
  input  logic                                            mem_error
);
  localparam int BB    = DATA_WIDTH / 8;
  localparam int BEATS = LINE_SIZE / BB;
  localparam int IW    = $clog2(BEATS);
  localparam int BO    = $clog2(BB);
  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [IW-1:0]         beat;
  logic [IW-1:0]         start;
  logic [IW:0]           cnt;
  logic                  err;
`ifdef L1_FILL_CRITICAL_WORD_FIRST_EN
  assign start = fill_addr[$clog2(LINE_SIZE)-1:BO];
`else
  assign start = '0;
`endif
  assign mem_addr       = base | (ADDR_WIDTH'(beat) << BO);
  assign mem_read       = mem_request;
  assign mem_write      = 1'b0;
  assign mem_write_data = '0;
  // IDLE moves through GAP so every beat, including the first, sees a fresh request edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      base            <= '0;
      beat            <= '0;
      cnt             <= '0;
      err             <= 1'b0;
      fill_ack        <= 1'b0;
      fill_beat_valid <= 1'b0;
      fill_beat_data  <= '0;
      fill_beat_idx   <= '0;
      fill_done       <= 1'b0;
      fill_error      <= 1'b0;
      line_data       <= '0;
      mem_id          <= '0;
      mem_request     <= 1'b0;
    end else begin
      fill_ack        <= 1'b0;
      fill_beat_valid <= 1'b0;
      fill_done       <= 1'b0;
      fill_error      <= 1'b0;
      case (state)
        IDLE: if (fill_req) begin
          base     <= fill_addr & ~ADDR_WIDTH'(LINE_SIZE - 1);
          mem_id   <= fill_id;
          beat     <= start;
          cnt      <= '0;
          err      <= 1'b0;
          fill_ack <= 1'b1;
          state    <= GAP;
        end
        REQ: if (mem_ready) begin
          mem_request <= 1'b0;
          err         <= mem_error;
          state       <= mem_error ? DONE : GAP;
          if (!mem_error) begin
            line_data[beat*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
            fill_beat_valid <= 1'b1;
            fill_beat_data  <= mem_read_data;
            fill_beat_idx   <= beat;
            beat            <= beat + 1'b1;
            cnt             <= cnt + 1'b1;
          end
        end
        GAP: if (cnt == (IW+1)'(BEATS)) state <= DONE;
        else begin
          mem_request <= 1'b1;
          state       <= REQ;
        end
        default: begin
          fill_done  <= 1'b1;
          fill_error <= err;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l1_line_fill_unit.sv
// tb_l1_line_fill_unit: scoreboard bench for l1_line_fill_unit with a latency-programmable memory model
module tb_l1_line_fill_unit;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fill_req = 1'b0;
  logic [63:0]  fill_addr = '0;
  logic [3:0]   fill_id = '0;
  logic         fill_ack, fill_beat_valid, fill_done, fill_error;
  logic [63:0]  fill_beat_data;
  logic [2:0]   fill_beat_idx;
  logic [511:0] line_data;
  logic [63:0]  mem_addr, mem_write_data;
  logic         mem_read, mem_write, mem_request;
  logic [3:0]   mem_id;
  logic [63:0]  mem_read_data;
  logic         mem_ready, mem_error;
  int           mem_lat = 4;
  logic [63:0]  err_addr = '1;
  bit           gap_poke = 1'b0;
  int           inj_req = 0;
  int           inj_done;
  logic [511:0] exp_line = '0;
  int           vectors = 0;
  int           miscompares = 0;

  l1_line_fill_unit dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .fill_addr(fill_addr), .fill_id(fill_id),
    .fill_ack(fill_ack), .fill_beat_valid(fill_beat_valid), .fill_beat_data(fill_beat_data),
    .fill_beat_idx(fill_beat_idx), .fill_done(fill_done), .fill_error(fill_error),
    .line_data(line_data), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_id(mem_id), .mem_request(mem_request),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [63:0] a);
    for (int j = 0; j < 8; j++) word[j*8 +: 8] = 8'(a + 64'(j));
  endfunction

  // Memory: ready appears mem_lat cycles after the request is first visible
  initial begin
    int  k;
    bit  real_rdy, pl;
    k = 0; real_rdy = 0; inj_done = 0;
    mem_ready = 0; mem_error = 0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      pl = real_rdy;
      real_rdy = 0;
      mem_ready = 0;
      mem_error = 0;
      if (inj_done != inj_req) begin
        inj_done = inj_req;
        mem_ready = 1; mem_error = 1; mem_read_data = '1;
      end else if (pl && gap_poke) begin
        mem_ready = 1; mem_error = 1; mem_read_data = '1;
      end else if (mem_request) begin
        if (k == mem_lat) begin
          mem_ready = 1;
          mem_read_data = word(mem_addr);
          mem_error = (mem_addr == err_addr);
          real_rdy = 1;
          k = 0;
        end else k++;
      end else k = 0;
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    logic any;
    any = 0;
    repeat (n) begin
      @(posedge clk); #1;
      any |= fill_beat_valid | fill_ack | fill_done | mem_request;
    end
    chk(tag, any, 1'b0);
  endtask

  task automatic do_fill(input logic [63:0] addr, input logic [3:0] id, input int lat,
                         input logic [63:0] eaddr, input bit keep, input logic [63:0] next);
    logic [63:0] q_addr[$];
    logic [63:0] q_data[$];
    int          q_idx[$];
    logic [63:0] base;
    int          s, ack_c, cyc, acks;
    bit          eexp, done, prq;
    base = addr & ~64'h3f;
`ifdef L1_FILL_CRITICAL_WORD_FIRST_EN
    s = int'(addr[5:3]);
`else
    s = 0;
`endif
    eexp = 0;
    for (int k = 0; k < 8; k++) begin
      int          b;
      logic [63:0] a;
      b = (s + k) % 8;
      a = base + 64'(b * 8);
      q_addr.push_back(a);
      if (a == eaddr) begin
        eexp = 1;
        break;
      end
      q_data.push_back(word(a));
      q_idx.push_back(b);
      exp_line[b*64 +: 64] = word(a);
    end
    mem_lat = lat; err_addr = eaddr;
    fill_addr = addr; fill_id = id; fill_req = 1;
    cyc = 0; acks = 0; ack_c = 0; done = 0; prq = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (fill_ack) begin
        acks++;
        if (acks == 1) begin
          ack_c = cyc;
          chk("ack_cycle", cyc, 1);
          if (keep) fill_addr = next;
          else fill_req = 0;
        end
      end
      if (mem_request && !prq) begin
        chk("req_expected", q_addr.size() > 0, 1'b1);
        if (q_addr.size() > 0) begin
          chk("mem_addr", mem_addr, q_addr.pop_front());
          chk("mem_id", mem_id, id);
          chk("mem_read", mem_read, 1'b1);
        end
      end
      prq = mem_request;
      if (fill_beat_valid) begin
        chk("beat_expected", q_data.size() > 0, 1'b1);
        if (q_data.size() > 0) begin
          chk("beat_idx", fill_beat_idx, q_idx.pop_front());
          chk("beat_data", fill_beat_data, q_data.pop_front());
        end
      end
      if (fill_done) done = 1;
    end
    chk("done_seen", done, 1'b1);
    chk("ack_count", acks, 1);
    chk("fill_error", fill_error, eexp);
    if (!eexp) chk("latency", cyc - ack_c, 8 * (lat + 2) + 2);
    chk("beats_left", q_data.size(), 0);
    chk("reqs_left", q_addr.size(), 0);
    chk("line_data", line_data, exp_line);
  endtask

  initial begin
    int n;
    bit prq;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_request", mem_request, 1'b0);
    chk("rst_ack", fill_ack, 1'b0);
    chk("rst_done", fill_done, 1'b0);
    chk("rst_line", line_data, '0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_id", mem_id, '0);
    chk("write_const", {mem_write, mem_write_data}, '0);
    @(negedge clk);
    rst = 0;

    do_fill(64'h1000, 4'd3, 4, '1, 0, '0);
    chk("beat0_word", line_data[63:0], 64'h0706050403020100);
    do_fill(64'h2028, 4'd5, 1, '1, 0, '0);
    gap_poke = 1;
    do_fill(64'h3000, 4'd2, 0, '1, 0, '0);
    gap_poke = 0;
    do_fill(64'h5000, 4'd9, 2, 64'h5010, 0, '0);
    quiet("req_after_err", 10);
    do_fill(64'h4000, 4'd1, 3, '1, 1, 64'h8000);
    do_fill(64'h8000, 4'd4, 3, '1, 0, '0);
    inj_req++;
    quiet("idle_ready_ignored", 4);

    mem_lat = 4; err_addr = '1;
    fill_addr = 64'h1000; fill_id = 4'd7; fill_req = 1;
    n = 0; prq = 0;
    for (int c = 0; c < 500 && n < 5; c++) begin
      @(posedge clk); #1;
      if (fill_ack) fill_req = 0;
      if (mem_request && !prq) n++;
      prq = mem_request;
    end
    chk("beat4_reached", n, 5);
    #2 rst = 1;
    #1;
    chk("async_rst_request", mem_request, 1'b0);
    chk("async_rst_valid", fill_beat_valid, 1'b0);
    chk("async_rst_done", fill_done, 1'b0);
    chk("async_rst_line", line_data, '0);
    exp_line = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    inj_req++;
    quiet("late_ready_ignored", 4);
    do_fill(64'h1000, 4'd3, 4, '1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
